pll_cfg_loader: RTL

Host-side front end for the PLL DRP sequencer, running in the `clk_sys_i` domain. It accepts a stream of 40-bit reconfiguration entries (DRP address, keep-mask, set-value) and writes each one into the sequencer's configuration RAM through the `r_pll_ctl0`/`r_pll_ctl1` register pair. After the last entry it pulses the trigger with the correct register count, then tracks the sequencer's busy flag, which arrives from the reconfiguration clock domain, until the PLL relocks or a timeout expires.

---
 rtl/pll_cfg_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_cfg_loader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared constants for the PLL DRP configuration loader: ctl0 field layout,
// error codes and controller state encoding.
package pll_cfg_pkg;

    localparam int unsigned ADDR_LSB = 0;
    localparam int unsigned WE_BIT   = 5;
    localparam int unsigned TRIG_BIT = 6;
    localparam int unsigned NREG_LSB = 7;
    localparam int unsigned DHI_LSB  = 16;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_OVERFLOW = 2'd1;
    localparam logic [1:0] ERR_START_TO = 2'd2;
    localparam logic [1:0] ERR_DONE_TO  = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWe,
        StHold,
        StTrig,
        StWaitStart,
        StWaitDone
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_cfg_loader.sv
// Loads a stream of 40-bit DRP entries into the sequencer RAM via ctl0/ctl1,
// triggers the sequencer and tracks its busy flag until relock or timeout.
module pll_cfg_loader
    import pll_cfg_pkg::*;
#(
    parameter int unsigned TRIG_HOLD = 8,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned TO_W      = 16
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        ent_valid_i,
    output logic        ent_ready_o,
    input  logic [39:0] ent_data_i,
    input  logic        ent_last_i,
    output logic [31:0] r_pll_ctl0_o,
    output logic [31:0] r_pll_ctl1_o,
    input  logic        seq_busy_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  err_code_o
);

    localparam logic [TO_W-1:0] TRIG_LAST = TO_W'(TRIG_HOLD - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    state_e          state_q;
    logic [5:0]      cnt_q;
    logic [39:0]     data_q;
    logic            last_q;
    logic [4:0]      addr_q;
    logic [4:0]      nreg_q;
    logic            we_q;
    logic            trig_q;
    logic [TO_W-1:0] tmr_q;
    logic            ready_q;
    logic            busy_q;
    logic            done_q;
    logic            error_q;
    logic [1:0]      err_q;
    logic            seq_busy_s;
    logic [31:0]     ctl0;

    sync_2ff u_busy_sync (
        .clk (clk_sys_i),
        .rst (rst_i),
        .d   (seq_busy_i),
        .q   (seq_busy_s)
    );

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            nreg_q  <= '0;
            we_q    <= 1'b0;
            trig_q  <= 1'b0;
            tmr_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ent_valid_i && ready_q) begin
                        err_q <= ERR_NONE;
                        if (cnt_q == 6'd32) begin
                            // RAM full: drop the entry and restart indexing.
                            err_q   <= ERR_OVERFLOW;
                            error_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            data_q  <= ent_data_i;
                            last_q  <= ent_last_i;
                            addr_q  <= cnt_q[4:0];
                            nreg_q  <= '0;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= StSetup;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                StSetup: begin
                    we_q    <= 1'b1;
                    state_q <= StWe;
                end
                StWe: begin
                    we_q    <= 1'b0;
                    state_q <= StHold;
                end
                StHold: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (last_q) begin
                        // 32 entries wrap to a count of 0, which the sequencer expects.
                        nreg_q  <= 5'(cnt_q + 6'd1);
                        trig_q  <= 1'b1;
                        tmr_q   <= '0;
                        state_q <= StTrig;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StTrig: begin
                    if (tmr_q == TRIG_LAST) begin
                        trig_q  <= 1'b0;
                        tmr_q   <= '0;
                        state_q <= StWaitStart;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StWaitStart: begin
                    if (seq_busy_s) begin
                        tmr_q   <= '0;
                        state_q <= StWaitDone;
                    end else if (tmr_q == TO_LAST) begin
                        err_q   <= ERR_START_TO;
                        error_q <= 1'b1;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!seq_busy_s) begin
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (tmr_q == TO_LAST) begin
                        err_q   <= ERR_DONE_TO;
                        error_q <= 1'b1;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        ctl0                    = '0;
        ctl0[ADDR_LSB +: 5]     = addr_q;
        ctl0[WE_BIT]            = we_q;
        ctl0[TRIG_BIT]          = trig_q;
        ctl0[NREG_LSB +: 5]     = nreg_q;
        ctl0[DHI_LSB +: 8]      = data_q[39:32];
    end

    assign r_pll_ctl0_o = ctl0;
    assign r_pll_ctl1_o = data_q[31:0];
    assign ent_ready_o  = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign err_code_o   = err_q;

endmodule
